adder_share_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one registered 32-bit adder (`Adder_32bit`, one-cycle registered latency) among up to NUM_REQ requesters, such as PC+4, branch-target and address-generation users. Each requester offers one operand pair under a valid/ready handshake. The arbiter grants one requester, holds that pair on the adder for the adder's latency, and returns the sum tagged with the requester index on a response channel that supports backpressure. It sits between the requesting datapath units and the single adder instance.

---
 rtl/adder_share_arbiter.sv | 139 +++++++++++++
 tb/tb_adder_share_arbiter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/adder_share_arbiter.sv
// adder_share_arbiter: round-robin arbiter/sequencer sharing one registered
// adder among NUM_REQ requesters, with a backpressured tagged response.
// Optional feature macro: ADDER_ARB_OVF_EN (enables the signed overflow flag).
module adder_share_arbiter #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
   input  logic                       clk,
   input  logic                       resetn,
   input  logic [NUM_REQ-1:0]         req_valid,
   input  logic [NUM_REQ*WIDTH-1:0]   req_a,
   input  logic [NUM_REQ*WIDTH-1:0]   req_b,
   output logic [NUM_REQ-1:0]         req_ready,
   output logic [WIDTH-1:0]           add_a,
   output logic [WIDTH-1:0]           add_b,
   input  logic [WIDTH-1:0]           add_result,
   output logic                       rsp_valid,
   input  logic                       rsp_ready,
   output logic [ID_W-1:0]            rsp_id,
   output logic [WIDTH-1:0]           rsp_sum,
   output logic                       rsp_ovf
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t            r_state;
   logic [ID_W-1:0]   r_rr_ptr;
   logic [WIDTH-1:0]  r_op_a;
   logic [WIDTH-1:0]  r_op_b;
   logic [ID_W-1:0]   r_rsp_id;
   logic              r_rsp_valid;

   logic              w_found;
   logic [ID_W-1:0]   w_grant;
   logic [ID_W-1:0]   w_idx;
   logic              w_window;
   logic              w_accept;
   logic [ID_W-1:0]   w_next_ptr;
   logic [WIDTH-1:0]  w_sel_a;
   logic [WIDTH-1:0]  w_sel_b;

   // Round-robin search: first valid requester at or above rr_ptr, wrapping.
   always_comb begin
      w_found = 1'b0;
      w_grant = '0;
      w_idx   = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         w_idx = ID_W'((32'(r_rr_ptr) + k) % NUM_REQ);
         if (!w_found && req_valid[w_idx]) begin
            w_found = 1'b1;
            w_grant = w_idx;
         end
      end
   end

   // Accept window is IDLE, or RESP while the current response drains.
   always_comb begin
      w_window   = (r_state == S_IDLE) || ((r_state == S_RESP) && rsp_ready);
      w_accept   = resetn && w_window && w_found;
      w_next_ptr = ID_W'((32'(w_grant) + 32'd1) % NUM_REQ);
      w_sel_a    = req_a[32'(w_grant)*WIDTH +: WIDTH];
      w_sel_b    = req_b[32'(w_grant)*WIDTH +: WIDTH];
   end

   // One-hot ready for the granted requester; all zero in reset or outside window.
   always_comb begin
      req_ready = '0;
      if (w_accept) begin
         req_ready[w_grant] = 1'b1;
      end
   end

   // Sequencer: latch operands on accept, one EXEC cycle, hold RESP until drained.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_state     <= S_IDLE;
         r_rr_ptr    <= '0;
         r_op_a      <= '0;
         r_op_b      <= '0;
         r_rsp_id    <= '0;
         r_rsp_valid <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_op_a   <= w_sel_a;
                  r_op_b   <= w_sel_b;
                  r_rsp_id <= w_grant;
                  r_rr_ptr <= w_next_ptr;
                  r_state  <= S_EXEC;
               end
            end
            S_EXEC: begin
               r_rsp_valid <= 1'b1;
               r_state     <= S_RESP;
            end
            S_RESP: begin
               if (rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  if (w_accept) begin
                     r_op_a   <= w_sel_a;
                     r_op_b   <= w_sel_b;
                     r_rsp_id <= w_grant;
                     r_rr_ptr <= w_next_ptr;
                     r_state  <= S_EXEC;
                  end else begin
                     r_state  <= S_IDLE;
                  end
               end
            end
            default: begin
               r_rsp_valid <= 1'b0;
               r_state     <= S_IDLE;
            end
         endcase
      end
   end

   assign add_a     = r_op_a;
   assign add_b     = r_op_b;
   assign rsp_valid = r_rsp_valid;
   assign rsp_id    = r_rsp_id;
   assign rsp_sum   = r_rsp_valid ? add_result : '0;

`ifdef ADDER_ARB_OVF_EN
   // Signed overflow: like-signed operands producing an opposite-signed sum.
   assign rsp_ovf = r_rsp_valid
                    && (r_op_a[WIDTH-1] == r_op_b[WIDTH-1])
                    && (add_result[WIDTH-1] != r_op_a[WIDTH-1]);
`else
   assign rsp_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_adder_share_arbiter.sv
// tb_adder_share_arbiter: directed vector table plus hand-written sequences
// for round-robin, backpressure and mid-operation reset.
module tb_adder_share_arbiter;

   localparam int unsigned NUM_REQ = 4;
   localparam int unsigned WIDTH   = 32;
   localparam int unsigned ID_W    = 2;

`ifdef ADDER_ARB_OVF_EN
   localparam logic OVF_EXP = 1'b1;
`else
   localparam logic OVF_EXP = 1'b0;
`endif

   logic                     clk;
   logic                     resetn;
   logic [NUM_REQ-1:0]       req_valid;
   logic [NUM_REQ*WIDTH-1:0] req_a;
   logic [NUM_REQ*WIDTH-1:0] req_b;
   logic [NUM_REQ-1:0]       req_ready;
   logic [WIDTH-1:0]         add_a;
   logic [WIDTH-1:0]         add_b;
   logic [WIDTH-1:0]         add_result;
   logic                     rsp_valid;
   logic                     rsp_ready;
   logic [ID_W-1:0]          rsp_id;
   logic [WIDTH-1:0]         rsp_sum;
   logic                     rsp_ovf;

   int n_checks;
   int n_errors;

   adder_share_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH)) dut (
      .clk        (clk),
      .resetn     (resetn),
      .req_valid  (req_valid),
      .req_a      (req_a),
      .req_b      (req_b),
      .req_ready  (req_ready),
      .add_a      (add_a),
      .add_b      (add_b),
      .add_result (add_result),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_id     (rsp_id),
      .rsp_sum    (rsp_sum),
      .rsp_ovf    (rsp_ovf)
   );

   // Shared adder model: one-cycle registered sum.
   always @(posedge clk) add_result <= add_a + add_b;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int          idx;
      logic [31:0] a;
      logic [31:0] b;
      logic [3:0]  exp_ready;
      logic [31:0] exp_sum;
      logic        exp_ovf;
   } vec_t;

   vec_t vecs[5];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
      req_a[i*WIDTH +: WIDTH] = a;
      req_b[i*WIDTH +: WIDTH] = b;
   endtask

   initial begin
      n_checks  = 0;
      n_errors  = 0;
      resetn    = 1'b0;
      req_valid = 4'b1111;
      req_a     = '0;
      req_b     = '0;
      rsp_ready = 1'b1;

      vecs[0] = '{2, 32'h0000_0004, 32'h0000_1000, 4'b0100, 32'h0000_1004, 1'b0};
      vecs[1] = '{0, 32'hFFFF_FFFF, 32'h0000_0002, 4'b0001, 32'h0000_0001, 1'b0};
      vecs[2] = '{1, 32'h7FFF_FFFF, 32'h0000_0001, 4'b0010, 32'h8000_0000, OVF_EXP};
      vecs[3] = '{0, 32'h1234_5678, 32'h1111_1111, 4'b0001, 32'h2345_6789, 1'b0};
      vecs[4] = '{3, 32'h8000_0000, 32'h8000_0000, 4'b1000, 32'h0000_0000, OVF_EXP};

      // Reset state, with all requesters valid to check the forced-zero ready.
      tick();
      tick();
      chk("rst_req_ready", 64'(req_ready), 64'h0);
      chk("rst_rsp_valid", 64'(rsp_valid), 64'h0);
      chk("rst_add_a",     64'(add_a),     64'h0);
      chk("rst_rsp_id",    64'(rsp_id),    64'h0);
      chk("rst_rsp_ovf",   64'(rsp_ovf),   64'h0);
      chk("rst_rsp_sum",   64'(rsp_sum),   64'h0);
      req_valid = '0;
      resetn    = 1'b1;
      tick();

      // Single-request vectors.
      for (int v = 0; v < 5; v++) begin
         set_op(vecs[v].idx, vecs[v].a, vecs[v].b);
         req_valid = vecs[v].exp_ready;
         #1;
         chk("vec_ready", 64'(req_ready), 64'(vecs[v].exp_ready));
         tick();
         req_valid = '0;
         #1;
         chk("vec_exec_ready", 64'(req_ready), 64'h0);
         chk("vec_exec_valid", 64'(rsp_valid), 64'h0);
         chk("vec_add_a",      64'(add_a),     64'(vecs[v].a));
         chk("vec_add_b",      64'(add_b),     64'(vecs[v].b));
         tick();
         chk("vec_rsp_valid", 64'(rsp_valid), 64'h1);
         chk("vec_rsp_id",    64'(rsp_id),    64'(vecs[v].idx));
         chk("vec_rsp_sum",   64'(rsp_sum),   64'(vecs[v].exp_sum));
         chk("vec_rsp_ovf",   64'(rsp_ovf),   64'(vecs[v].exp_ovf));
         tick();
         chk("vec_idle_valid", 64'(rsp_valid), 64'h0);
         chk("vec_idle_sum",   64'(rsp_sum),   64'h0);
      end

      // Round-robin with all requesters valid; sums wrap to 0x11*i.
      for (int i = 0; i < 4; i++) set_op(i, 32'hA000_0000 + 32'(i), 32'h6000_0000 + 32'(16*i));
      req_valid = 4'b1111;
      #1;
      chk("rr_first_ready", 64'(req_ready), 64'h1);
      for (int k = 0; k < 8; k++) begin
         tick();
         chk("rr_exec_valid", 64'(rsp_valid), 64'h0);
         chk("rr_exec_ready", 64'(req_ready), 64'h0);
         tick();
         chk("rr_rsp_valid", 64'(rsp_valid), 64'h1);
         chk("rr_rsp_id",    64'(rsp_id),    64'(k % 4));
         chk("rr_rsp_sum",   64'(rsp_sum),   64'(32'h11 * 32'(k % 4)));
         chk("rr_rsp_ovf",   64'(rsp_ovf),   64'h0);
         if (k < 7) begin
            chk("rr_next_ready", 64'(req_ready), 64'(4'b0001 << ((k + 1) % 4)));
         end else begin
            req_valid = '0;
            #1;
            chk("rr_last_ready", 64'(req_ready), 64'h0);
         end
      end
      tick();
      chk("rr_idle_valid", 64'(rsp_valid), 64'h0);

      // Backpressure: hold RESP for 5 cycles while requester 3 waits.
      set_op(1, 32'd10, 32'd20);
      set_op(3, 32'd1000, 32'd2000);
      req_valid = 4'b0010;
      #1;
      chk("bp_ready1", 64'(req_ready), 64'h2);
      tick();
      req_valid = 4'b1000;
      rsp_ready = 1'b0;
      #1;
      chk("bp_exec_ready", 64'(req_ready), 64'h0);
      tick();
      for (int c = 0; c < 5; c++) begin
         chk("bp_hold_valid", 64'(rsp_valid), 64'h1);
         chk("bp_hold_id",    64'(rsp_id),    64'h1);
         chk("bp_hold_sum",   64'(rsp_sum),   64'd30);
         chk("bp_hold_ready", 64'(req_ready), 64'h0);
         tick();
      end
      rsp_ready = 1'b1;
      #1;
      chk("bp_release_ready", 64'(req_ready), 64'h8);
      tick();
      req_valid = '0;
      #1;
      chk("bp_exec_valid", 64'(rsp_valid), 64'h0);
      tick();
      chk("bp_rsp3_valid", 64'(rsp_valid), 64'h1);
      chk("bp_rsp3_id",    64'(rsp_id),    64'h3);
      chk("bp_rsp3_sum",   64'(rsp_sum),   64'd3000);
      tick();

      // Reset during EXEC after granting requester 2 (rr_ptr would be 3).
      set_op(2, 32'd5, 32'd6);
      set_op(1, 32'd100, 32'd200);
      req_valid = 4'b0100;
      #1;
      chk("rst_mid_grant", 64'(req_ready), 64'h4);
      tick();
      resetn    = 1'b0;
      req_valid = 4'b1010;
      #1;
      chk("rst_mid_forced", 64'(req_ready), 64'h0);
      tick();
      chk("rst_mid_valid", 64'(rsp_valid), 64'h0);
      chk("rst_mid_ready", 64'(req_ready), 64'h0);
      chk("rst_mid_add_a", 64'(add_a),     64'h0);
      resetn = 1'b1;
      #1;
      chk("rst_rel_grant", 64'(req_ready), 64'h2);
      tick();
      req_valid = '0;
      #1;
      chk("rst_rel_exec", 64'(rsp_valid), 64'h0);
      tick();
      chk("rst_rel_valid", 64'(rsp_valid), 64'h1);
      chk("rst_rel_id",    64'(rsp_id),    64'h1);
      chk("rst_rel_sum",   64'(rsp_sum),   64'd300);
      tick();
      chk("rst_rel_idle", 64'(rsp_valid), 64'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
